// File: rtl/lfsr_fair_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_fair_arbiter_if : request/grant bundle between requesters and arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface lfsr_fair_arbiter_if #(
  parameter int NUM_REQS   = 8,
  parameter int LFSR_WIDTH = 16
);
  localparam int IDXW = $clog2(NUM_REQS);

  logic [LFSR_WIDTH-1:0] lfsr_seed;
  logic                  seed_load;
  logic                  mode;
  logic [NUM_REQS-1:0]   req;
  logic [NUM_REQS-1:0]   grant;
  logic [IDXW-1:0]       grant_idx;
  logic                  grant_valid;
  logic                  starve_event;

  modport master (
    output lfsr_seed, seed_load, mode, req,
    input  grant, grant_idx, grant_valid, starve_event
  );

  modport slave (
    input  lfsr_seed, seed_load, mode, req,
    output grant, grant_idx, grant_valid, starve_event
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_fair_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_fair_arbiter : LFSR-random / round-robin arbiter with bounded hold
//                     time and a starvation override.
// Rev 1.0
// ----------------------------------------------------------------------------
module lfsr_fair_arbiter #(
  parameter int                    NUM_REQS     = 8,
  parameter int                    LFSR_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = 16'hB400,
  parameter int                    HOLD_CYCLES  = 4,
  parameter int                    STARVE_LIMIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  lfsr_fair_arbiter_if.slave bus
);
  localparam int IDXW  = $clog2(NUM_REQS);
  localparam int c_HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int c_WW  = $clog2(STARVE_LIMIT + 1);
  localparam int c_IW1 = IDXW + 1;
  localparam logic [IDXW:0]     c_NUM       = c_IW1'(NUM_REQS);
  localparam logic [IDXW-1:0]   c_LAST      = IDXW'(NUM_REQS - 1);
  localparam logic [c_HW-1:0]   c_HOLD_LAST = c_HW'(HOLD_CYCLES - 1);
  localparam logic [c_WW-1:0]   c_LIMIT     = c_WW'(STARVE_LIMIT);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                r_state;
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [NUM_REQS-1:0]   r_grant;
  logic [IDXW-1:0]       r_owner;
  logic [IDXW-1:0]       r_last_idx;
  logic [c_HW-1:0]       r_hold_cnt;
  logic [c_WW-1:0]       r_wait [NUM_REQS];
  logic                  r_starve;

  logic [LFSR_WIDTH-1:0] w_seed_val;
  logic [IDXW:0]         w_rnd_ext, w_sum;
  logic [IDXW-1:0]       w_rnd_start, w_rr_start, w_start, w_off, w_norm;
  logic [IDXW-1:0]       w_starve_idx, w_win;
  logic [NUM_REQS-1:0]   w_rot, w_starved, w_win_oh;
  logic                  w_any, w_any_starved, w_arb;

  assign w_seed_val  = (bus.lfsr_seed == '0) ? LFSR_WIDTH'(1) : bus.lfsr_seed;

  // 2^IDXW < 2*NUM_REQS, so a single subtraction folds the LFSR slice into range
  assign w_rnd_ext   = {1'b0, r_lfsr[IDXW-1:0]};
  assign w_rnd_start = (w_rnd_ext >= c_NUM) ? IDXW'(w_rnd_ext - c_NUM) : r_lfsr[IDXW-1:0];
  assign w_rr_start  = (r_last_idx == c_LAST) ? '0 : r_last_idx + 1'b1;
  assign w_start     = bus.mode ? w_rr_start : w_rnd_start;

  // Rotate so the start index sits at bit 0; the first set bit is the offset
  assign w_rot  = NUM_REQS'({bus.req, bus.req} >> w_start);
  assign w_sum  = {1'b0, w_start} + {1'b0, w_off};
  assign w_norm = (w_sum >= c_NUM) ? IDXW'(w_sum - c_NUM) : w_sum[IDXW-1:0];

  always_comb begin
    w_off        = '0;
    w_starve_idx = '0;
    w_starved    = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDXW'(i);
      if (bus.req[i] && (r_wait[i] == c_LIMIT)) begin
        w_starved[i] = 1'b1;
        w_starve_idx = IDXW'(i);
      end
    end
  end

  assign w_any         = |bus.req;
  assign w_any_starved = |w_starved;
  assign w_win         = w_any_starved ? w_starve_idx : w_norm;
  assign w_win_oh      = NUM_REQS'(1) << w_win;
  assign w_arb         = (r_state == ST_IDLE) || !bus.req[r_owner] ||
                         (r_hold_cnt == c_HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst || bus.seed_load) r_lfsr <= w_seed_val;
    else                      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rst || !bus.req[i] || r_grant[i]) r_wait[i] <= '0;
      else if (r_wait[i] != c_LIMIT)        r_wait[i] <= r_wait[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_last_idx <= c_LAST;
      r_hold_cnt <= '0;
      r_starve   <= 1'b0;
    end else if (w_arb) begin
      r_hold_cnt <= '0;
      if (w_any) begin
        r_state    <= ST_HOLD;
        r_grant    <= w_win_oh;
        r_owner    <= w_win;
        r_last_idx <= w_win;
        r_starve   <= w_any_starved;
      end else begin
        r_state    <= ST_IDLE;
        r_grant    <= '0;
        r_owner    <= '0;
        r_starve   <= 1'b0;
      end
    end else begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
      r_starve   <= 1'b0;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.grant_idx    = r_owner;
  assign bus.grant_valid  = |r_grant;
  assign bus.starve_event = r_starve;
endmodule
`default_nettype wire

// File: tb/tb_lfsr_fair_arbiter.sv
`default_nettype none
// tb_lfsr_fair_arbiter : two arbiter instances (starve limits 16 and 8) driven
// with shared stimulus and checked every cycle against a behavioural model.
module tb_lfsr_fair_arbiter;
  localparam int N    = 4;
  localparam int W    = 16;
  localparam int TAPS = 'hB400;
  localparam int HOLD = 4;
  localparam int IDXW = $clog2(N);

  int lim [2] = '{16, 8};

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic [W-1:0] t_seed = '0;
  logic         t_load = 1'b0;
  logic         t_mode = 1'b0;
  logic [N-1:0] t_req  = '0;

  always #5 clk = ~clk;

  lfsr_fair_arbiter_if #(.NUM_REQS(N), .LFSR_WIDTH(W)) if0 ();
  lfsr_fair_arbiter_if #(.NUM_REQS(N), .LFSR_WIDTH(W)) if1 ();

  assign if0.lfsr_seed = t_seed;
  assign if0.seed_load = t_load;
  assign if0.mode      = t_mode;
  assign if0.req       = t_req;
  assign if1.lfsr_seed = t_seed;
  assign if1.seed_load = t_load;
  assign if1.mode      = t_mode;
  assign if1.req       = t_req;

  lfsr_fair_arbiter #(.NUM_REQS(N), .LFSR_WIDTH(W), .LFSR_TAPS(16'hB400),
                      .HOLD_CYCLES(HOLD), .STARVE_LIMIT(16))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));

  lfsr_fair_arbiter #(.NUM_REQS(N), .LFSR_WIDTH(W), .LFSR_TAPS(16'hB400),
                      .HOLD_CYCLES(HOLD), .STARVE_LIMIT(8))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Reference state: owner -1 means nothing granted
  int m_lfsr [2];
  int m_owner[2];
  int m_hold [2];
  int m_last [2];
  int m_wait [2][N];
  int m_starve[2];

  int n_chk = 0;
  int n_err = 0;

  int           gcnt [N];
  int           maxw;
  logic [N-1:0] stim [64];
  int           mtrace [64];

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int s, start, win, forced, arb;
    int nw[N];
    s = m_lfsr[k];
    if (rst) begin
      m_lfsr[k]   = (t_seed == 0) ? 1 : int'(t_seed);
      m_owner[k]  = -1;
      m_hold[k]   = 0;
      m_last[k]   = N - 1;
      m_starve[k] = 0;
      for (int i = 0; i < N; i++) m_wait[k][i] = 0;
      return;
    end
    m_lfsr[k] = t_load ? ((t_seed == 0) ? 1 : int'(t_seed))
                       : ((s >> 1) ^ (((s % 2) == 1) ? TAPS : 0));
    arb = (m_owner[k] < 0) || !t_req[m_owner[k]] || (m_hold[k] == HOLD - 1);
    win = -1;
    forced = 0;
    if (arb != 0) begin
      for (int i = 0; i < N; i++)
        if (win < 0 && t_req[i] && m_wait[k][i] == lim[k]) begin
          win = i;
          forced = 1;
        end
      if (win < 0) begin
        if (t_mode) start = (m_last[k] + 1) % N;
        else begin
          start = s % (1 << IDXW);
          if (start >= N) start = start - N;
        end
        for (int d = 0; d < N; d++)
          if (win < 0 && t_req[(start + d) % N]) win = (start + d) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!t_req[i] || m_owner[k] == i) nw[i] = 0;
      else nw[i] = (m_wait[k][i] + 1 > lim[k]) ? lim[k] : m_wait[k][i] + 1;
    end
    if (arb != 0) begin
      m_owner[k]  = win;
      m_hold[k]   = 0;
      m_starve[k] = forced;
      if (win >= 0) m_last[k] = win;
    end else begin
      m_hold[k]   = m_hold[k] + 1;
      m_starve[k] = 0;
    end
    for (int i = 0; i < N; i++) m_wait[k][i] = nw[i];
  endtask

  task automatic compare(input int k);
    int g, gi, gv, se, lf, hc;
    if (k == 0) begin
      g  = int'(if0.grant);        gi = int'(if0.grant_idx);
      gv = int'(if0.grant_valid);  se = int'(if0.starve_event);
      lf = int'(u_dut0.r_lfsr);    hc = int'(u_dut0.r_hold_cnt);
    end else begin
      g  = int'(if1.grant);        gi = int'(if1.grant_idx);
      gv = int'(if1.grant_valid);  se = int'(if1.starve_event);
      lf = int'(u_dut1.r_lfsr);    hc = int'(u_dut1.r_hold_cnt);
    end
    check($sformatf("i%0d grant", k),  g,  (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0);
    check($sformatf("i%0d idx", k),    gi, (m_owner[k] >= 0) ? m_owner[k] : 0);
    check($sformatf("i%0d valid", k),  gv, (m_owner[k] >= 0) ? 1 : 0);
    check($sformatf("i%0d starve", k), se, m_starve[k]);
    check($sformatf("i%0d lfsr", k),   lf, m_lfsr[k]);
    check($sformatf("i%0d hold", k),   hc, m_hold[k]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic do_reset(input logic [W-1:0] seed);
    rst    = 1'b1;
    t_seed = seed;
    step();
    rst    = 1'b0;
  endtask

  initial begin
    // Reset with a zero seed
    rst = 1'b1; t_seed = '0; t_req = '1;
    step();
    check("rst lfsr",  int'(u_dut0.r_lfsr), 1);
    check("rst grant", int'(if0.grant), 0);
    check("rst valid", int'(if0.grant_valid), 0);
    rst = 1'b0;

    // Round-robin with all four requesting
    t_mode = 1'b1; t_req = 4'b1111;
    for (int j = 1; j <= 32; j++) begin
      step();
      check("rr seq", int'(if0.grant), 1 << (((j - 1) / 4) % 4));
    end

    // Lone requester keeps the grant, hold counter wraps
    do_reset(16'h00A5);
    t_req = 4'b0100;
    for (int j = 1; j <= 12; j++) begin
      step();
      check("solo grant", int'(if0.grant), 4);
      check("solo idx",   int'(if0.grant_idx), 2);
      check("solo hold",  int'(u_dut0.r_hold_cnt), (j - 1) % 4);
    end

    // Owner drops mid-hold; switch straight to the other requester
    do_reset(16'h1234);
    t_mode = 1'b1; t_req = 4'b0010;
    step(); step();
    check("own1 hold", int'(u_dut0.r_hold_cnt), 1);
    t_req = 4'b1000;
    step();
    check("switch grant",  int'(if0.grant), 8);
    check("switch starve", int'(if0.starve_event), 0);

    // Random mode, everyone requesting, starve limit 8 on instance 1
    do_reset(16'hACE1);
    t_mode = 1'b0; t_req = '1;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    maxw = 0;
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        check("i1 wait", int'(u_dut1.r_wait[i]), m_wait[1][i]);
        if (int'(u_dut1.r_wait[i]) > maxw) maxw = int'(u_dut1.r_wait[i]);
      end
      if (if1.grant_valid) gcnt[if1.grant_idx]++;
    end
    check("max wait <= 8", (maxw <= 8) ? 1 : 0, 1);
    for (int i = 0; i < N; i++) check($sformatf("granted %0d", i), (gcnt[i] > 0) ? 1 : 0, 1);

    // Fully random traffic including seed loads and resets
    do_reset(W'($urandom));
    for (int c = 0; c < 400; c++) begin
      t_req  = N'($urandom);
      t_mode = 1'($urandom);
      t_load = ($urandom_range(0, 15) == 0);
      t_seed = W'($urandom);
      rst    = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; t_load = 1'b0;

    // Same seed load and stimulus twice give the same grant trace
    for (int i = 0; i < 64; i++) stim[i] = N'($urandom);
    for (int p = 0; p < 2; p++) begin
      do_reset(16'h0001);
      t_mode = 1'b0; t_req = '0; t_seed = 16'h5A5A; t_load = 1'b1;
      step();
      t_load = 1'b0;
      for (int i = 0; i < 64; i++) begin
        t_req = stim[i];
        step();
        if (p == 0) mtrace[i] = (m_owner[0] >= 0) ? (1 << m_owner[0]) : 0;
        else        check("replay grant", int'(if0.grant), mtrace[i]);
      end
    end

    // Reset in the middle of a hold
    t_req = '1;
    step(); step();
    rst = 1'b1;
    step();
    check("midhold rst grant", int'(if0.grant), 0);
    check("midhold rst valid", int'(if0.grant_valid), 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lfsr_fair_arbiter.md
LFSR_FAIR_ARBITER -- requirements
Module: lfsr_fair_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_REQS, default 8, as the requester count (legal 2..32).
REQ-002 The block SHALL take parameter LFSR_WIDTH, default 16, as the LFSR state width (legal 8..32, and 2^LFSR_WIDTH >= 2*NUM_REQS).
REQ-003 The block SHALL take parameter LFSR_TAPS, default 16'hB400, as the Galois feedback mask.
REQ-004 The block SHALL take parameter HOLD_CYCLES, default 4, as the maximum number of cycles per grant (legal >= 1).
REQ-005 The block SHALL take parameter STARVE_LIMIT, default 16, as the wait-cycle threshold for forced grant (legal >= 2).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-008 The block SHALL have port lfsr_seed, input, LFSR_WIDTH bits: the LFSR load value.
REQ-009 The block SHALL have port seed_load, input, 1 bit: loads lfsr_seed into the LFSR at the next edge.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 selects random start, 1 selects round-robin.
REQ-011 The block SHALL have port req, input, NUM_REQS bits: requests, level-sensitive.
REQ-012 The block SHALL have port grant, output, NUM_REQS bits: registered, one-hot or zero.
REQ-013 The block SHALL have port grant_idx, output, IDXW = clog2(NUM_REQS) bits: index of the current owner.
REQ-014 The block SHALL have port grant_valid, output, 1 bit: equal to |grant.
REQ-015 The block SHALL have port starve_event, output, 1 bit: one-cycle pulse aligned with a forced grant.

Function
REQ-016 The LFSR SHALL advance every cycle as a right-shift Galois LFSR: next = (s>>1) ^ (s[0] ? LFSR_TAPS : 0).
REQ-017 On seed_load the LFSR SHALL take lfsr_seed, or 1 if lfsr_seed is 0, instead of advancing.
REQ-018 In random mode the start index SHALL be s[IDXW-1:0], minus NUM_REQS if it is >= NUM_REQS.
REQ-019 In round-robin mode the start index SHALL be (last_idx+1) mod NUM_REQS, where last_idx is the most recent owner.
REQ-020 Normal selection SHALL be the first asserted req scanning upward from the start index with wrap-around.
REQ-021 Each requester SHALL have a wait_cnt that increments while req[i]=1 and grant[i]=0, clears when grant[i]=1 or req[i]=0, and saturates at STARVE_LIMIT.
REQ-022 At arbitration, if any wait_cnt equals STARVE_LIMIT, the lowest-index such requester SHALL win, overriding REQ-020, and starve_event SHALL be 1 in the cycle its grant first appears.
REQ-023 The FSM SHALL have states IDLE and HOLD, with hold_cnt tracking cycles in HOLD.
REQ-024 In IDLE with any req asserted, the block SHALL arbitrate and register grant at the next edge (1-cycle latency), set hold_cnt=0, and go to HOLD; with req all zero it SHALL remain in IDLE with grant=0.
REQ-025 In HOLD the grant SHALL be held and hold_cnt incremented while req[owner]=1 and hold_cnt < HOLD_CYCLES-1.
REQ-026 A release SHALL occur when req[owner]=0 or hold_cnt = HOLD_CYCLES-1.
REQ-027 On release the block SHALL re-arbitrate in the same cycle over the current req (the owner is eligible if still requesting); the new grant appears at the next edge with hold_cnt=0, or the block goes to IDLE with grant=0 if no req is asserted.
REQ-028 A grant SHALL never be held for more than HOLD_CYCLES consecutive cycles without re-arbitration.
REQ-029 With HOLD_CYCLES=1 the block SHALL re-arbitrate every cycle.
REQ-030 last_idx SHALL update on every new grant; grant_idx SHALL equal the owner index when grant_valid=1, and 0 otherwise.
REQ-031 If req[owner] drops and other requesters are asserted in the same cycle, the grant SHALL switch directly to the new winner with no idle cycle.
REQ-032 The block SHALL never assert grant[i] for a requester with req[i]=0 at the arbitration cycle.

Reset
REQ-033 With rst=1 at an edge, grant, grant_idx, grant_valid, starve_event, hold_cnt and all wait_cnt SHALL become 0, the FSM SHALL go to IDLE, last_idx SHALL become NUM_REQS-1, and the LFSR SHALL take lfsr_seed (1 if zero).
REQ-034 rst SHALL take priority over seed_load and over any in-progress HOLD; grant SHALL be 0 in the cycle after a reset edge.

Verification
REQ-035 The bench SHALL cover: rst=1 with lfsr_seed=0 -> LFSR=1, grant=0, grant_valid=0 after the edge.
REQ-036 The bench SHALL cover: NUM_REQS=4, HOLD_CYCLES=4, mode=1, req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, each lasting exactly 4 cycles, repeating.
REQ-037 The bench SHALL cover: req=4'b0100 only, asserted at cycle t -> grant=4'b0100 and grant_idx=2 from t+1, continuous, with hold_cnt wrapping 0..3.
REQ-038 The bench SHALL cover: owner 1 drops req at hold_cnt=1 while req[3]=1 -> grant=4'b1000 on the next edge, and starve_event=0.
REQ-039 The bench SHALL cover: mode=0, STARVE_LIMIT=8, all requests held for 2000 cycles -> no wait_cnt exceeds 8, each starve_event grants the lowest starved index, and every requester is granted.
REQ-040 The bench SHALL cover: an identical seed_load value and identical req stimulus applied twice -> identical grant traces; reset asserted mid-HOLD -> grant=0 on the next cycle.
